// File: rtl/johnson_counter_param.sv
// johnson_counter_param
//   Twisted-ring (Johnson) counter of WIDTH bits cycling through 2*WIDTH
//   states. Supports enable, direction, synchronous load with a legality
//   check, a registered binary state index, a wrap strobe and recovery
//   from illegal (upset) codes.
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   en         advance one step this cycle
//   dir        0 = forward, 1 = reverse
//   load       synchronous load of load_val (wins over en)
//   load_val   value to load
//   dout       registered counter state
//   state_idx  registered position of dout in the forward sequence
//   wrap       1-cycle pulse when a counting step lands on all-0
//   err        1-cycle pulse when an illegal code was loaded or detected
module johnson_counter_param #(
  parameter int WIDTH = 4,
  localparam int IDX_W = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] dout,
  output logic [IDX_W-1:0] state_idx,
  output logic             wrap,
  output logic             err
);

  // Legal codes have at most one transition between adjacent bits:
  // the adjacent-XOR vector must have zero or one bit set.
  function automatic logic f_legal(input logic [WIDTH-1:0] v);
    logic [WIDTH-2:0] t;
    t = v[WIDTH-1:1] ^ v[WIDTH-2:0];
    return (t & (t - (WIDTH-1)'(1))) == '0;
  endfunction

  function automatic logic [IDX_W-1:0] f_popcnt(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + IDX_W'(v[i]);
    return c;
  endfunction

  logic [WIDTH-1:0] r_dout;
  logic [IDX_W-1:0] r_idx;
  logic             r_wrap;
  logic             r_err;

  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_step;
  logic [IDX_W-1:0] w_pc;
  logic [IDX_W-1:0] w_idx;
  logic             w_wrap;
  logic             w_err;

  // Forward shifts right, feeding the inverted LSB into the MSB; reverse
  // is its exact inverse.
  assign w_step = dir ? {r_dout[WIDTH-2:0], ~r_dout[WIDTH-1]}
                      : {~r_dout[0], r_dout[WIDTH-1:1]};

  always_comb begin
    w_nxt  = r_dout;
    w_wrap = 1'b0;
    w_err  = 1'b0;
    if (load) begin
      if (f_legal(load_val)) begin
        w_nxt = load_val;
      end else begin
        w_nxt = '0;
        w_err = 1'b1;
      end
    end else if (!f_legal(r_dout)) begin
      w_nxt = '0;
      w_err = 1'b1;
    end else if (en) begin
      w_nxt  = w_step;
      w_wrap = (w_step == '0);
    end
  end

  // Index from the next value: top-aligned ones count up from 1..WIDTH,
  // bottom-aligned ones are the descending half. IDX_W'(2*WIDTH) may
  // truncate to 0 for power-of-two moduli; the subtraction stays correct
  // modulo 2^IDX_W and the result is always below 2*WIDTH.
  assign w_pc = f_popcnt(w_nxt);
  always_comb begin
    w_idx = '0;
    if (w_nxt == '0)            w_idx = '0;
    else if (w_nxt[WIDTH-1])    w_idx = w_pc;
    else                        w_idx = IDX_W'(2*WIDTH) - w_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout <= '0;
      r_idx  <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_dout <= w_nxt;
      r_idx  <= w_idx;
      r_wrap <= w_wrap;
      r_err  <= w_err;
    end
  end

  assign dout      = r_dout;
  assign state_idx = r_idx;
  assign wrap      = r_wrap;
  assign err       = r_err;

endmodule
